// File: rtl/multicycle_control_fsm_if.sv
// Control/handshake bundle between the multi-cycle sequencer and the RV32 datapath + shared memory.
// master = sequencer, slave = datapath/memory side.
interface multicycle_control_fsm_if;
  logic       run;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic       pc_write_cond;
  logic       pc_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic       mem_to_reg;
  logic       illegal_op;
  logic       instr_done;

  // mem_req/mem_ready: a request is held stable until the cycle mem_ready is high, which completes it.
  modport master (
    input  run, opcode, zero, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, illegal_op, instr_done
  );

  modport slave (
    output run, opcode, zero, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, illegal_op, instr_done
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32 sequencer (R-type, lw, sw, beq, addi): Moore controls per state,
// memory req/ready handshake and a retired-instruction counter.
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  multicycle_control_fsm_if.master    bus,
  output logic [3:0]                  state,
  output logic [CNT_W-1:0]            instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic       reg_write, mem_to_reg, illegal_op, instr_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Controls are forced low while rst_n is asserted so nothing leaks out during an abort.
  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    illegal_op    = 1'b0;
    instr_done    = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          if (bus.run) begin
            mem_req   = 1'b1;
            alu_src_b = 2'b01;
            if (bus.mem_ready) begin
              ir_write = 1'b1;
              pc_write = 1'b1;
              state_d  = S_DECODE;
            end
          end
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          case (bus.opcode)
            OP_R:         state_d = S_EXEC_R;
            OP_I:         state_d = S_EXEC_I;
            OP_LW, OP_SW: state_d = S_ADDR;
            OP_BEQ:       state_d = S_BRANCH;
            default: begin
              illegal_op = 1'b1;
              state_d    = S_FETCH;
            end
          endcase
        end
        S_EXEC_R: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b10;
          state_d   = S_WB_ALU;
        end
        S_EXEC_I: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b10;
          state_d   = S_WB_ALU;
        end
        S_ADDR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b10;
          state_d   = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (bus.mem_ready) state_d = S_WB_MEM;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
          if (bus.mem_ready) begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        end
        S_WB_ALU: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a     = 2'b10;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_src        = 1'b1;
          instr_done    = 1'b1;
          state_d       = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign count_d = instr_done ? count_q + {{(CNT_W-1){1'b0}}, 1'b1} : count_q;

  assign bus.mem_req       = mem_req;
  assign bus.mem_we        = mem_we;
  assign bus.iord          = iord;
  assign bus.ir_write      = ir_write;
  assign bus.pc_write      = pc_write;
  assign bus.pc_write_cond = pc_write_cond;
  assign bus.pc_src        = pc_src;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.alu_op        = alu_op;
  assign bus.reg_write     = reg_write;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.illegal_op    = illegal_op;
  assign bus.instr_done    = instr_done;

  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: driver pushes expected per-cycle state/controls/count,
// a negedge monitor pops and compares.
module tb_multicycle_control_fsm;

  localparam int W = 53;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src, a[1:0], b[1:0], op[1:0],
  //  reg_write, mem_to_reg, illegal_op, instr_done}
  localparam logic [16:0] C_IDLE       = 17'b0_0_0_0_0_0_0_00_00_00_0_0_0_0;
  localparam logic [16:0] C_FETCH_WAIT = 17'b1_0_0_0_0_0_0_00_01_00_0_0_0_0;
  localparam logic [16:0] C_FETCH_GO   = 17'b1_0_0_1_1_0_0_00_01_00_0_0_0_0;
  localparam logic [16:0] C_DECODE     = 17'b0_0_0_0_0_0_0_01_10_00_0_0_0_0;
  localparam logic [16:0] C_DECODE_ILL = 17'b0_0_0_0_0_0_0_01_10_00_0_0_1_0;
  localparam logic [16:0] C_EXEC_R     = 17'b0_0_0_0_0_0_0_10_00_10_0_0_0_0;
  localparam logic [16:0] C_EXEC_I     = 17'b0_0_0_0_0_0_0_10_10_00_0_0_0_0;
  localparam logic [16:0] C_ADDR       = 17'b0_0_0_0_0_0_0_10_10_00_0_0_0_0;
  localparam logic [16:0] C_MEM_RD     = 17'b1_0_1_0_0_0_0_00_00_00_0_0_0_0;
  localparam logic [16:0] C_MEM_WR_W   = 17'b1_1_1_0_0_0_0_00_00_00_0_0_0_0;
  localparam logic [16:0] C_MEM_WR_GO  = 17'b1_1_1_0_0_0_0_00_00_00_0_0_0_1;
  localparam logic [16:0] C_WB_ALU     = 17'b0_0_0_0_0_0_0_00_00_00_1_0_0_1;
  localparam logic [16:0] C_WB_MEM     = 17'b0_0_0_0_0_0_0_00_00_00_1_1_0_1;
  localparam logic [16:0] C_BRANCH     = 17'b0_0_0_0_0_1_1_10_00_01_0_0_0_1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_fsm_if bus ();
  multicycle_control_fsm_if bus4 ();

  logic [3:0]  state, state4;
  logic [31:0] instr_count;
  logic [3:0]  instr_count4;

  multicycle_control_fsm #(.CNT_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.master),
    .state       (state),
    .instr_count (instr_count)
  );

  multicycle_control_fsm #(.CNT_W(4)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus4.master),
    .state       (state4),
    .instr_count (instr_count4)
  );

  assign bus4.run       = bus.run;
  assign bus4.opcode    = bus.opcode;
  assign bus4.zero      = bus.zero;
  assign bus4.mem_ready = bus.mem_ready;

  logic [16:0] act_ctrl;
  assign act_ctrl = {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write,
                     bus.pc_write_cond, bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                     bus.reg_write, bus.mem_to_reg, bus.illegal_op, bus.instr_done};

  // scoreboard
  logic [W-1:0] exp_q[$];
  int unsigned  exp_count = 0;
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check("state", {28'd0, state}, {28'd0, e[52:49]});
      check("controls", {15'd0, act_ctrl}, {15'd0, e[48:32]});
      check("instr_count", instr_count, e[31:0]);
    end
  end

  // driver: one call = one clock cycle of stimulus plus its expected response
  task automatic cyc(input logic rn, input logic run, input logic rdy, input logic [6:0] op,
                     input logic z, input logic [3:0] st, input logic [16:0] ctrl);
    @(posedge clk);
    #1;
    rst_n         = rn;
    bus.run       = run;
    bus.mem_ready = rdy;
    bus.opcode    = op;
    bus.zero      = z;
    if (!rn) exp_count = 0;
    exp_q.push_back({st, ctrl, exp_count});
    if (ctrl[0]) exp_count++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.run = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode = OP_BAD;
    bus.zero = 1'b0;

    // reset: controls low even with run/mem_ready high
    cyc(0, 1, 1, OP_R, 0, 4'd0, C_IDLE);
    cyc(0, 1, 1, OP_R, 0, 4'd0, C_IDLE);

    // R-type, zero-wait
    cyc(1, 1, 1, OP_BAD, 0, 4'd0, C_FETCH_GO);
    cyc(1, 1, 1, OP_R,   0, 4'd1, C_DECODE);
    cyc(1, 1, 1, OP_BAD, 0, 4'd2, C_EXEC_R);
    cyc(1, 1, 0, OP_BAD, 0, 4'd7, C_WB_ALU);

    // run low: idle in FETCH, mem_ready ignored
    cyc(1, 0, 1, OP_R, 0, 4'd0, C_IDLE);
    cyc(1, 0, 1, OP_R, 0, 4'd0, C_IDLE);

    // lw with 2 fetch waits and 3 memory waits: 10 cycles
    cyc(1, 1, 0, OP_BAD, 0, 4'd0, C_FETCH_WAIT);
    cyc(1, 1, 0, OP_BAD, 0, 4'd0, C_FETCH_WAIT);
    cyc(1, 1, 1, OP_BAD, 0, 4'd0, C_FETCH_GO);
    cyc(1, 1, 1, OP_LW,  0, 4'd1, C_DECODE);
    cyc(1, 1, 1, OP_LW,  0, 4'd4, C_ADDR);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, OP_BAD, 0, 4'd5, C_MEM_RD);
    cyc(1, 1, 1, OP_BAD, 0, 4'd5, C_MEM_RD);
    cyc(1, 0, 1, OP_BAD, 0, 4'd8, C_WB_MEM);

    // beq taken then not taken: controls identical
    for (int z = 1; z >= 0; z--) begin
      cyc(1, 1, 1, OP_BAD, z[0], 4'd0, C_FETCH_GO);
      cyc(1, 1, 1, OP_BEQ, z[0], 4'd1, C_DECODE);
      cyc(1, 1, 1, OP_BAD, z[0], 4'd9, C_BRANCH);
    end

    // sw with one write wait
    cyc(1, 1, 1, OP_BAD, 0, 4'd0, C_FETCH_GO);
    cyc(1, 1, 1, OP_SW,  0, 4'd1, C_DECODE);
    cyc(1, 1, 1, OP_SW,  0, 4'd4, C_ADDR);
    cyc(1, 1, 0, OP_LW,  0, 4'd6, C_MEM_WR_W);
    cyc(1, 1, 1, OP_LW,  0, 4'd6, C_MEM_WR_GO);

    // addi
    cyc(1, 1, 1, OP_BAD, 0, 4'd0, C_FETCH_GO);
    cyc(1, 1, 1, OP_I,   0, 4'd1, C_DECODE);
    cyc(1, 1, 1, OP_BAD, 0, 4'd3, C_EXEC_I);
    cyc(1, 1, 1, OP_BAD, 0, 4'd7, C_WB_ALU);

    // illegal opcode: pulse in DECODE, back to FETCH, not counted
    cyc(1, 1, 1, OP_BAD, 0, 4'd0, C_FETCH_GO);
    cyc(1, 1, 1, OP_BAD, 0, 4'd1, C_DECODE_ILL);
    cyc(1, 0, 1, OP_BAD, 0, 4'd0, C_IDLE);

    // reset during MEM_RD wait aborts the lw
    cyc(1, 1, 1, OP_BAD, 0, 4'd0, C_FETCH_GO);
    cyc(1, 1, 1, OP_LW,  0, 4'd1, C_DECODE);
    cyc(1, 1, 1, OP_LW,  0, 4'd4, C_ADDR);
    cyc(1, 1, 0, OP_LW,  0, 4'd5, C_MEM_RD);
    cyc(0, 1, 0, OP_LW,  0, 4'd0, C_IDLE);
    cyc(0, 1, 1, OP_LW,  0, 4'd0, C_IDLE);

    // 17 beqs from reset: narrow counter wraps to 1
    for (int i = 0; i < 17; i++) begin
      logic z;
      z = 1'($urandom_range(0, 1));
      cyc(1, 1, 1, OP_BAD, z, 4'd0, C_FETCH_GO);
      cyc(1, 1, 1, OP_BEQ, z, 4'd1, C_DECODE);
      cyc(1, 1, 1, OP_BAD, z, 4'd9, C_BRANCH);
    end

    @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 32'd0);
    check("count_final", instr_count, exp_count);
    check("count_wrap_cnt4", {28'd0, instr_count4}, exp_count % 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Sequencing controller for the multi-cycle variant of the RV32 datapath (R-type, lw, sw, beq, addi). Walks each instruction through fetch/decode/execute/memory/writeback states. Drives per-cycle enables and mux selects for PC, IR, ALU, register file and a shared instruction/data memory with a req/ready handshake. Also keeps a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter instr_count

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  when low, FSM idles in FETCH without issuing mem_req
opcode  in  7  instr[6:0] from IR, valid from DECODE onward
zero  in  1  ALU zero flag (beq condition)
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  request is a write (sw)
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
ir_write  out  1  load IR and OldPC from memory read data / PC
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load qualified by zero (datapath ANDs; this block also exposes pc_write_cond only)
pc_src  out  1  PC source: 0 = ALU result, 1 = ALUOut
alu_src_a  out  2  00 PC, 01 OldPC, 10 reg A
alu_src_b  out  2  00 reg B, 01 constant 4, 10 immediate
alu_op  out  2  00 add, 01 subtract/compare, 10 funct-decoded
reg_write  out  1  register file write enable
mem_to_reg  out  1  writeback source: 0 ALUOut, 1 MDR
illegal_op  out  1  one-cycle pulse on unsupported opcode
instr_done  out  1  one-cycle pulse when an instruction retires
state  out  4  current state encoding (debug)
instr_count  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, rst_n=0): state=FETCH, instr_count=0; all outputs 0 while in reset.
- Outputs are Moore, decoded from state only. Exceptions: ir_write/pc_write in FETCH are gated by mem_ready.
- Any signal not listed for a state is 0.
- States (encoding 0..9): FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH.
- FETCH:
  - If run=0: no outputs, stay in FETCH.
  - If run=1: mem_req=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=00, pc_src=0.
  - When mem_ready=1: ir_write=1, pc_write=1, next state DECODE. Otherwise stay; all controls held stable.
- DECODE: alu_src_a=01, alu_src_b=10, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> ADDR
  - 1100011 -> BRANCH
  - any other opcode: illegal_op=1 this cycle, next state FETCH, not counted.
- EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10 -> WB_ALU.
- EXEC_I: alu_src_a=10, alu_src_b=10, alu_op=00 -> WB_ALU.
- ADDR: alu_src_a=10, alu_src_b=10, alu_op=00. Next MEM_RD if opcode=0000011, else MEM_WR.
- MEM_RD: mem_req=1, iord=1. On mem_ready -> WB_MEM, else stay.
- MEM_WR: mem_req=1, mem_we=1, iord=1. On mem_ready: instr_done=1, -> FETCH; else stay.
- WB_ALU: reg_write=1, mem_to_reg=0, instr_done=1 -> FETCH.
- WB_MEM: reg_write=1, mem_to_reg=1, instr_done=1 -> FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=1, instr_done=1 -> FETCH. PC updates only if zero=1.
- Latency with zero-wait memory (mem_ready=1 on first req cycle):
  - beq 3 cycles
  - R-type/addi/sw 4 cycles
  - lw 5 cycles
  - each wait cycle adds 1.
- instr_count increments on every instr_done cycle, wraps modulo 2^CNT_W.
- opcode is sampled only in DECODE and ADDR; changes elsewhere are ignored.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- run is sampled only in FETCH. An instruction in flight always completes regardless of run.
- rst_n asserted mid-instruction aborts immediately: no partial reg_write/mem_req after reset release; restart in FETCH.

Test Plan:
- Reset then run=1, mem_ready=1, opcode=0110011 -> states FETCH,DECODE,EXEC_R,WB_ALU; reg_write=1 in cycle 4 only; instr_done pulse; instr_count=1.
- lw (0000011) with mem_ready low for 2 cycles in FETCH and 3 in MEM_RD -> total 10 cycles; mem_req and iord stable during waits; mem_to_reg=1 with reg_write in WB_MEM.
- beq with zero=1 then zero=0 -> 3 cycles each; pc_write_cond=1, pc_src=1 in BRANCH both times; instr_count +2; no reg_write, no mem_req after FETCH.
- sw (0100011) -> MEM_WR with mem_we=1, iord=1; instr_done on the mem_ready cycle; reg_write never asserted.
- opcode=1111111 -> illegal_op pulses in DECODE, return to FETCH, instr_count unchanged; run=0 holds FETCH with mem_req=0.
- rst_n pulsed low during MEM_RD wait -> immediate state=FETCH, all outputs 0, instr_count=0; CNT_W=4 with 17 retired instructions -> instr_count=1.
